// File: rtl/ddp_token_io.sv
// ddp_token_io: turns BIN level changes into {SEQ,BIN} tokens for a 4-phase send to the DDP, and
// captures DDP results from a second 4-phase channel onto LED. Send rises one edge after the push.
// Backpressure: tokens queue in a DEPTH-entry FIFO; a change that meets a full FIFO is dropped (STAT[0]).
// Build option: define DDP_TOKEN_TIMEOUT_EN to abandon a TX handshake after TO_CYC cycles (STAT[1]).
module ddp_token_io #(
   parameter int DEPTH  = 4,
   parameter int TO_CYC = 1024
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [3:0] BIN,
   output logic       Send_in_DDP,
   input  logic       Ack_in_DDP,
   output logic [7:0] Data_in_DDP,
   input  logic       Send_out_DDP,
   output logic       Ack_out_DDP,
   input  logic [7:0] Data_out_DDP,
   output logic [3:0] LED,
   output logic [1:0] STAT
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic [1:0] {IDLE, REQ, REL} tx_state_t;
   typedef enum logic       {R_IDLE, R_ACK}  rx_state_t;

   // change detection and sequence numbering
   logic [3:0]    bin_q;
   logic [3:0]    seq;
   logic          chg;
   logic          push;
   logic          ovf_q;

   // token FIFO
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_empty;
   logic          fifo_full;
   logic [7:0]    fifo_head;
   logic          pop;

   // synchronizers for the two asynchronous handshake inputs
   logic [1:0]    ack_sync;
   logic [1:0]    send_sync;
   logic          ack_s;
   logic          send_s;

   // TX side
   tx_state_t     tx_state;
   tx_state_t     tx_next;
   logic          send_nxt;

   // RX side
   rx_state_t     rx_state;
   rx_state_t     rx_next;
   logic          ack_out_nxt;
   logic          capture;
   logic [7:0]    rx_dat;
   logic [3:0]    unused_rx_hi;

   assign chg        = (BIN != bin_q);
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FULL_CNT);
   assign fifo_head  = fifo_mem[rd_ptr];
   // a full FIFO still accepts a token when the head leaves in the same cycle
   assign push       = chg && (!fifo_full || pop);
   assign ack_s      = ack_sync[1];
   assign send_s     = send_sync[1];

   // sample BIN, number accepted tokens, remember any dropped token
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bin_q <= 4'd0;
         seq   <= 4'd0;
         ovf_q <= 1'b0;
      end else begin
         bin_q <= BIN;
         if (push) begin
            seq <= seq + 4'd1;
         end
         if (chg && !push) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; reset discards everything queued
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO storage; contents are meaningless until written, so no reset
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {seq, BIN};
      end
   end

   // two-flop synchronizers for Ack_in_DDP and Send_out_DDP
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ack_sync  <= 2'b00;
         send_sync <= 2'b00;
      end else begin
         ack_sync  <= {ack_sync[0], Ack_in_DDP};
         send_sync <= {send_sync[0], Send_out_DDP};
      end
   end

`ifdef DDP_TOKEN_TIMEOUT_EN
   localparam int TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   logic [TW-1:0] to_cnt;
   logic          to_hit;
   logic          to_q;

   assign to_hit = (tx_state != IDLE) && (to_cnt == TO_LAST);

   // handshake watchdog: counts cycles spent in one non-idle state
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         to_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         if ((tx_state == IDLE) || (tx_next != tx_state)) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (to_hit) begin
            to_q <= 1'b1;
         end
      end
   end

   assign STAT = {to_q, ovf_q};
`else
   logic [31:0] unused_to_cyc;

   // no watchdog in this build: TO_CYC has no effect and STAT[1] stays low
   assign unused_to_cyc = TO_CYC;
   assign STAT          = {1'b0, ovf_q};
`endif

   // TX next state: start a token only from IDLE with the DDP ack seen low
   always_comb begin
      tx_next  = tx_state;
      send_nxt = Send_in_DDP;
      pop      = 1'b0;
      case (tx_state)
         IDLE: begin
            if (!fifo_empty && !ack_s) begin
               pop      = 1'b1;
               send_nxt = 1'b1;
               tx_next  = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               send_nxt = 1'b0;
               tx_next  = REL;
            end
         end
         REL: begin
            if (!ack_s) begin
               tx_next = IDLE;
            end
         end
         default: begin
            send_nxt = 1'b0;
            tx_next  = IDLE;
         end
      endcase
`ifdef DDP_TOKEN_TIMEOUT_EN
      if (to_hit) begin
         send_nxt = 1'b0;
         tx_next  = IDLE;
      end
`endif
   end

   // TX state, request line and token register (held until IDLE is re-entered)
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tx_state    <= IDLE;
         Send_in_DDP <= 1'b0;
         Data_in_DDP <= 8'd0;
      end else begin
         tx_state    <= tx_next;
         Send_in_DDP <= send_nxt;
         if (pop) begin
            Data_in_DDP <= fifo_head;
         end
      end
   end

   // RX next state: capture on synchronized send, release when it drops
   always_comb begin
      rx_next     = rx_state;
      ack_out_nxt = Ack_out_DDP;
      capture     = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (send_s) begin
               capture     = 1'b1;
               ack_out_nxt = 1'b1;
               rx_next     = R_ACK;
            end
         end
         R_ACK: begin
            if (!send_s) begin
               ack_out_nxt = 1'b0;
               rx_next     = R_IDLE;
            end
         end
         default: begin
            ack_out_nxt = 1'b0;
            rx_next     = R_IDLE;
         end
      endcase
   end

   // RX state, acknowledge line and captured result
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rx_state    <= R_IDLE;
         Ack_out_DDP <= 1'b0;
         rx_dat      <= 8'd0;
      end else begin
         rx_state    <= rx_next;
         Ack_out_DDP <= ack_out_nxt;
         if (capture) begin
            rx_dat <= Data_out_DDP;
         end
      end
   end

   // only the low nibble of a result drives anything
   assign LED          = rx_dat[3:0];
   assign unused_rx_hi = rx_dat[7:4];

endmodule
